// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM encoding and output saturation
// for the FIR multiply-accumulate sequencer.
package fir_pkg;

    localparam int DATA_W    = 24;
    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 17;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_W     = DATA_W + COEF_W + 8;
    localparam int RAM_W     = 36;
    localparam int ADDR_W    = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    // Half an output LSB, so the shift rounds half toward +inf
    localparam logic signed [ACC_W-1:0] RND =
        {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};

    function automatic logic [DATA_W-1:0] saturate(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] r;
        logic [ACC_W-DATA_W:0]   hi;
        r  = (a + RND) >>> COEF_FRAC;
        hi = r[ACC_W-1:DATA_W-1];
        if (&hi || ~|hi) begin
            return r[DATA_W-1:0];
        end
        return r[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                          : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fir_mac_dp.sv
// fir_mac_dp: read-data register, product register, clearable
// accumulator and the rounded/saturated output register.
module fir_mac_dp
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_issue,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_dl,
    input  logic [COEF_W-1:0] i_cf,
    output logic [DATA_W-1:0] o_sample
);

    logic                     r_rd_v;
    logic                     r_d_v;
    logic                     r_p_v;
    logic [DATA_W-1:0]        r_d;
    logic [COEF_W-1:0]        r_c;
    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0]        r_out;
    logic signed [PROD_W-1:0] w_dx;
    logic signed [PROD_W-1:0] w_cx;

    assign w_dx     = {{COEF_W{r_d[DATA_W-1]}}, r_d};
    assign w_cx     = {{DATA_W{r_c[COEF_W-1]}}, r_c};
    assign o_sample = r_out;

    // Valid bits follow each RAM read through data, product, accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v <= 1'b0;
            r_d_v  <= 1'b0;
            r_p_v  <= 1'b0;
            r_d    <= '0;
            r_c    <= '0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            r_rd_v <= i_issue;
            r_d_v  <= r_rd_v;
            r_p_v  <= r_d_v;
            if (r_rd_v) begin
                r_d <= i_dl;
                r_c <= i_cf;
            end
            if (r_d_v) begin
                r_prod <= w_dx * w_cx;
            end
            if (i_clr) begin
                r_acc <= '0;
            end else if (r_p_v) begin
                r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
            end
        end
    end

    // Output holds until the next sample finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (i_load) begin
            r_out <= saturate(r_acc);
        end
    end

endmodule

// File: rtl/ram_256x36.sv
// ram_256x36: true dual-port block RAM, registered read-before-write
// outputs on both ports, contents not affected by reset.
module ram_256x36 (
    input  logic        clk,
    input  logic        a_we,
    input  logic [7:0]  a_addr,
    input  logic [35:0] a_din,
    output logic [35:0] a_dout,
    input  logic        b_we,
    input  logic [7:0]  b_addr,
    input  logic [35:0] b_din,
    output logic [35:0] b_dout
);

    logic [35:0] r_mem [256];

    // Both ports read the old word and then write
    always_ff @(posedge clk) begin
        a_dout <= r_mem[a_addr];
        b_dout <= r_mem[b_addr];
        if (a_we) begin
            r_mem[a_addr] <= a_din;
        end
        if (b_we) begin
            r_mem[b_addr] <= b_din;
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: per-sample sequencer writing the delay line and walking
// all taps through the delay-line and coefficient RAM port A.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int TAPS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              dl_we,
    output logic [ADDR_W-1:0] dl_addr,
    output logic [RAM_W-1:0]  dl_din,
    input  logic [RAM_W-1:0]  dl_dout,
    output logic [ADDR_W-1:0] cf_addr,
    input  logic [RAM_W-1:0]  cf_dout
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_k;
    logic [1:0]        r_dc;
    logic              r_ov;
    logic              r_vld;
    logic              w_idle;
    logic              w_accept;
    logic              w_mac;
    logic              w_out;
    logic              w_unused;

    assign w_idle   = (r_state == S_IDLE);
    assign w_mac    = (r_state == S_MAC);
    assign w_out    = (r_state == S_OUT);
    assign w_accept = w_idle & sample_valid;
    assign w_unused = ^{dl_dout[RAM_W-1:DATA_W], cf_dout[RAM_W-1:COEF_W]};

    assign dl_we            = w_accept;
    assign dl_addr          = w_mac ? (r_wp - r_k) : r_wp;
    assign dl_din           = {{(RAM_W-DATA_W){sample_in[DATA_W-1]}}, sample_in};
    assign cf_addr          = r_k;
    assign busy             = ~w_idle;
    assign overrun          = r_ov;
    assign sample_out_valid = r_vld;

    // Sample sequencing: accept, issue taps, drain pipeline, emit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wp    <= '0;
            r_k     <= '0;
            r_dc    <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_state <= S_MAC;
                        r_k     <= '0;
                    end
                end
                S_MAC: begin
                    r_k <= r_k + 1'b1;
                    if (r_k == LAST) begin
                        r_state <= S_DRAIN;
                        r_k     <= '0;
                        r_dc    <= '0;
                    end
                end
                S_DRAIN: begin
                    r_dc <= r_dc + 1'b1;
                    if (r_dc == 2'd2) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    r_vld   <= 1'b1;
                    r_wp    <= r_wp + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flag for strobes dropped while a sample is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov <= 1'b0;
        end else if (sample_valid && !w_idle) begin
            r_ov <= 1'b1;
        end
    end

    fir_mac_dp u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept),
        .i_issue  (w_mac),
        .i_load   (w_out),
        .i_dl     (dl_dout[DATA_W-1:0]),
        .i_cf     (cf_dout[COEF_W-1:0]),
        .o_sample (sample_out)
    );

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: two filters (4 and 256 taps) against an arithmetic
// reference of the FIR sum with rounding and saturation.
module tb_fir_mac_seq;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        sv [2];
    logic [23:0] sin [2];
    logic [23:0] sout [2];
    logic        sov [2];
    logic        bsy [2];
    logic        ovr [2];
    logic        dwe [2];
    logic [7:0]  daddr [2];
    logic [7:0]  caddr [2];
    logic [35:0] ddin [2];
    logic [35:0] ddout [2];
    logic [35:0] cdout [2];
    logic        bwe [4];
    logic [7:0]  baddr [4];
    logic [35:0] bdin [4];
    logic [35:0] bdout [4];

    logic signed [23:0] hist [2][256];
    logic signed [17:0] coef [2][256];
    int mwp [2];
    int taps [2] = '{4, 256};
    int vec;
    int bad;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_u
        fir_mac_seq #(.TAPS(g == 0 ? 4 : 256)) u_dut (
            .clk              (clk),
            .rst_n            (rst[g]),
            .sample_in        (sin[g]),
            .sample_valid     (sv[g]),
            .sample_out       (sout[g]),
            .sample_out_valid (sov[g]),
            .busy             (bsy[g]),
            .overrun          (ovr[g]),
            .dl_we            (dwe[g]),
            .dl_addr          (daddr[g]),
            .dl_din           (ddin[g]),
            .dl_dout          (ddout[g]),
            .cf_addr          (caddr[g]),
            .cf_dout          (cdout[g])
        );
        ram_256x36 u_dl (
            .clk    (clk),
            .a_we   (dwe[g]),
            .a_addr (daddr[g]),
            .a_din  (ddin[g]),
            .a_dout (ddout[g]),
            .b_we   (bwe[2*g]),
            .b_addr (baddr[2*g]),
            .b_din  (bdin[2*g]),
            .b_dout (bdout[2*g])
        );
        ram_256x36 u_cf (
            .clk    (clk),
            .a_we   (1'b0),
            .a_addr (caddr[g]),
            .a_din  (36'd0),
            .a_dout (cdout[g]),
            .b_we   (bwe[2*g+1]),
            .b_addr (baddr[2*g+1]),
            .b_din  (bdin[2*g+1]),
            .b_dout (bdout[2*g+1])
        );
    end

    // Reference: store sample, form the FIR sum, round half up, clamp
    function automatic logic [23:0] push(input int u, input logic [23:0] s);
        longint acc;
        longint r;
        hist[u][mwp[u]] = s;
        acc = 0;
        for (int k = 0; k < taps[u]; k++)
            acc += longint'(hist[u][(mwp[u] - k) & 255]) * longint'(coef[u][k]);
        r = (acc + 65536) >>> 17;
        if (r > 8388607) r = 8388607;
        else if (r < -8388608) r = -8388608;
        mwp[u] = (mwp[u] + 1) & 255;
        return r[23:0];
    endfunction

    task automatic wr_ram(input int r, input int a, input logic [35:0] d);
        bwe[r] = 1'b1;
        baddr[r] = 8'(a);
        bdin[r] = d;
        @(posedge clk);
        @(negedge clk);
        bwe[r] = 1'b0;
    endtask

    task automatic peek(input int r, input int a, output logic [35:0] d);
        baddr[r] = 8'(a);
        @(posedge clk);
        @(negedge clk);
        d = bdout[r];
    endtask

    task automatic load_coefs(input int u);
        for (int k = 0; k < taps[u]; k++)
            wr_ram(2*u+1, k, {18'($urandom), coef[u][k]});
    endtask

    task automatic send(input int u, input logic [23:0] s,
                        output logic [23:0] got, output int lat);
        sv[u] = 1'b1;
        sin[u] = s;
        @(posedge clk);
        @(negedge clk);
        sv[u] = 1'b0;
        got = '0;
        lat = -1;
        for (int c = 1; c <= taps[u] + 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sov[u]) begin
                got = sout[u];
                lat = c;
                break;
            end
        end
    endtask

    task automatic strobe_pair(input int u, input logic [23:0] s1,
                               input logic [23:0] s2, input int at,
                               output int cnt, output logic [23:0] got,
                               output int lat);
        sv[u] = 1'b1;
        sin[u] = s1;
        @(posedge clk);
        @(negedge clk);
        sv[u] = 1'b0;
        cnt = 0;
        got = '0;
        lat = -1;
        for (int c = 1; c <= taps[u] + 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sov[u]) begin
                cnt++;
                got = sout[u];
                lat = c;
            end
            sv[u] = (c == at - 1);
            sin[u] = s2;
        end
        sv[u] = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            sv[u] = 1'b0;
            sin[u] = '0;
            mwp[u] = 0;
            for (int a = 0; a < 256; a++) begin
                hist[u][a] = '0;
                coef[u][a] = '0;
            end
        end
        for (int r = 0; r < 4; r++) begin
            bwe[r] = 1'b0;
            baddr[r] = '0;
            bdin[r] = '0;
        end
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            vec++;
            if ({bsy[u], sov[u], ovr[u], dwe[u], daddr[u], caddr[u], sout[u]} !== 44'd0) begin
                bad++;
                $display("FAIL reset_u%0d: got %h required 0", u,
                         {bsy[u], sov[u], ovr[u], dwe[u], daddr[u], caddr[u], sout[u]});
            end
        end
        for (int a = 0; a < 256; a++) begin
            for (int r = 0; r < 4; r++) begin
                bwe[r] = 1'b1;
                baddr[r] = 8'(a);
                bdin[r] = '0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int r = 0; r < 4; r++) bwe[r] = 1'b0;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            vec++;
            if ({bsy[u], sov[u]} !== 2'b00) begin
                bad++;
                $display("FAIL idle_u%0d: busy/valid %b required 00", u, {bsy[u], sov[u]});
            end
        end
    endtask

    task automatic test_impulse();
        logic [23:0] ins [4] = '{24'h100000, 24'h0, 24'h0, 24'h0};
        logic [23:0] exp [4] = '{24'h080000, 24'h040000, 24'h0, 24'h0};
        logic [23:0] got;
        int lat;
        coef[0][0] = 18'h10000;
        coef[0][1] = 18'h08000;
        coef[0][2] = 18'h0;
        coef[0][3] = 18'h0;
        load_coefs(0);
        for (int i = 0; i < 4; i++) begin
            void'(push(0, ins[i]));
            send(0, ins[i], got, lat);
            vec++;
            if (got !== exp[i]) begin
                bad++;
                $display("FAIL impulse[%0d]: got %h required %h", i, got, exp[i]);
            end
            vec++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL impulse_lat[%0d]: got %0d required 8", i, lat);
            end
        end
    endtask

    task automatic test_rounding();
        logic [23:0] got;
        int lat;
        coef[0][0] = 18'h10000;
        coef[0][1] = 18'h0;
        load_coefs(0);
        void'(push(0, 24'h000003));
        send(0, 24'h000003, got, lat);
        vec++;
        if (got !== 24'h000002) begin
            bad++;
            $display("FAIL round_pos: got %h required 000002", got);
        end
        void'(push(0, 24'hFFFFFD));
        send(0, 24'hFFFFFD, got, lat);
        vec++;
        if (got !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL round_neg: got %h required ffffff", got);
        end
    endtask

    task automatic test_saturation();
        logic [23:0] got;
        logic [23:0] e;
        logic [23:0] v [2] = '{24'h7FFFFF, 24'h800000};
        int lat;
        for (int k = 0; k < 4; k++) coef[0][k] = 18'h1FFFF;
        load_coefs(0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                e = push(0, v[p]);
                send(0, v[p], got, lat);
                vec++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL sat_model[%0d.%0d]: got %h required %h", p, i, got, e);
                end
            end
            vec++;
            if (got !== v[p]) begin
                bad++;
                $display("FAIL sat_fourth[%0d]: got %h required %h", p, got, v[p]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] s;
        logic [23:0] e;
        logic [23:0] got;
        logic [35:0] d;
        int lat;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) coef[0][k] = 18'($urandom);
            load_coefs(0);
            for (int i = 0; i < 12; i++) begin
                s = 24'($urandom);
                if (r == 2) s = (i % 2 == 1) ? 24'h7FFFFF : 24'h800000;
                e = push(0, s);
                send(0, s, got, lat);
                vec++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL rand_out[%0d.%0d]: got %h required %h", r, i, got, e);
                end
                vec++;
                if (lat !== 8) begin
                    bad++;
                    $display("FAIL rand_lat[%0d.%0d]: got %0d required 8", r, i, lat);
                end
                peek(0, (mwp[0] - 1) & 255, d);
                vec++;
                if (d !== {{12{s[23]}}, s}) begin
                    bad++;
                    $display("FAIL rand_dl[%0d.%0d]: got %h required %h", r, i, d, {{12{s[23]}}, s});
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        vec++;
        if (ovr[0] !== 1'b0) begin
            bad++;
            $display("FAIL rand_ovr: got %b required 0", ovr[0]);
        end
    endtask

    task automatic test_out_edge();
        logic [23:0] s1;
        logic [23:0] s2;
        logic [23:0] e;
        logic [23:0] got;
        logic [35:0] d;
        int cnt;
        int lat;
        s1 = 24'($urandom);
        e = push(0, s1);
        s2 = hist[0][mwp[0]] ^ 24'h5A5A5A;
        strobe_pair(0, s1, s2, 8, cnt, got, lat);
        vec++;
        if (cnt !== 1 || got !== e || lat !== 8) begin
            bad++;
            $display("FAIL out_edge: cnt %0d out %h lat %0d required 1 %h 8", cnt, got, lat, e);
        end
        vec++;
        if (ovr[0] !== 1'b1) begin
            bad++;
            $display("FAIL out_edge_ovr: got %b required 1", ovr[0]);
        end
        peek(0, mwp[0], d);
        vec++;
        if (d[23:0] !== hist[0][mwp[0]]) begin
            bad++;
            $display("FAIL out_edge_dl: got %h required %h", d[23:0], hist[0][mwp[0]]);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] e;
        logic [23:0] got;
        int lat;
        coef[1][255] = 18'h10000;
        load_coefs(1);
        for (int n = 0; n < 300; n++) begin
            e = push(1, 24'(n));
            send(1, 24'(n), got, lat);
            vec++;
            if (got !== e || lat !== 260) begin
                bad++;
                $display("FAIL wrap[%0d]: out %h lat %0d required %h 260", n, got, lat, e);
            end
            if (n >= 255) begin
                vec++;
                if (got !== 24'((n - 254) >> 1)) begin
                    bad++;
                    $display("FAIL wrap_half[%0d]: got %h required %h", n, got, 24'((n - 254) >> 1));
                end
            end
        end
        vec++;
        if (ovr[1] !== 1'b0) begin
            bad++;
            $display("FAIL wrap_ovr: got %b required 0", ovr[1]);
        end
    endtask

    task automatic test_overrun();
        logic [23:0] s1;
        logic [23:0] s2;
        logic [23:0] e;
        logic [23:0] got;
        logic [35:0] d;
        int cnt;
        int lat;
        s1 = 24'($urandom);
        e = push(1, s1);
        s2 = hist[1][mwp[1]] ^ 24'h5A5A5A;
        strobe_pair(1, s1, s2, 10, cnt, got, lat);
        vec++;
        if (cnt !== 1 || got !== e || lat !== 260) begin
            bad++;
            $display("FAIL overrun_out: cnt %0d out %h lat %0d required 1 %h 260", cnt, got, lat, e);
        end
        vec++;
        if (ovr[1] !== 1'b1) begin
            bad++;
            $display("FAIL overrun_flag: got %b required 1", ovr[1]);
        end
        peek(2, mwp[1], d);
        vec++;
        if (d !== {{12{hist[1][mwp[1]][23]}}, hist[1][mwp[1]]}) begin
            bad++;
            $display("FAIL overrun_dl: got %h required %h", d[23:0], hist[1][mwp[1]]);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] s;
        logic [23:0] e;
        logic [23:0] got;
        logic [35:0] d;
        int cnt;
        int lat;
        s = 24'($urandom);
        sv[1] = 1'b1;
        sin[1] = s;
        @(posedge clk);
        @(negedge clk);
        sv[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        #1;
        hist[1][mwp[1]] = s;
        mwp[1] = 0;
        vec++;
        if ({bsy[1], sov[1], ovr[1], daddr[1], caddr[1], sout[1]} !== 43'd0) begin
            bad++;
            $display("FAIL mid_reset: got %h required 0",
                     {bsy[1], sov[1], ovr[1], daddr[1], caddr[1], sout[1]});
        end
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (sov[1]) cnt++;
        end
        vec++;
        if (cnt !== 0) begin
            bad++;
            $display("FAIL mid_novalid: got %0d strobes required 0", cnt);
        end
        s = 24'($urandom);
        e = push(1, s);
        send(1, s, got, lat);
        vec++;
        if (got !== e || lat !== 260) begin
            bad++;
            $display("FAIL mid_next: out %h lat %0d required %h 260", got, lat, e);
        end
        peek(2, 0, d);
        vec++;
        if (d !== {{12{s[23]}}, s}) begin
            bad++;
            $display("FAIL mid_addr0: got %h required %h", d, {{12{s[23]}}, s});
        end
    endtask

    initial begin
        vec = 0;
        bad = 0;
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_random();
        test_out_edge();
        test_wrap();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Sequencer and multiply-accumulate datapath for the PmodI2S2 FIR filter. On each incoming audio sample it writes the sample into a circular delay line held in one 256x36 dual-port block RAM. It then walks all taps, reading delay-line and coefficient RAMs through their port A, and emits one rounded, saturated output sample. It sits between the I2S receiver (upstream) and the I2S transmitter (downstream); the coefficient RAM's port B is owned by the coefficient loader.

## Interface
- TAPS, 256: number of filter taps, legal range 1..256.
- DATA_W, 24: audio sample width, two's complement.
- COEF_W, 18: coefficient width, two's complement, stored in bits [COEF_W-1:0] of a coefficient RAM word.
- COEF_FRAC, 17: coefficient fractional bits (Q1.17).

Ports:
- clk  in  1  system clock; all logic is in this single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_W  input sample.
- sample_valid  in  1  one-cycle strobe qualifying sample_in.
- sample_out  out  DATA_W  filtered sample.
- sample_out_valid  out  1  one-cycle strobe qualifying sample_out.
- busy  out  1  high while a sample is being processed.
- overrun  out  1  sticky: sample_valid arrived while busy.
- dl_we  out  1  delay-line RAM port A write enable.
- dl_addr  out  8  delay-line RAM port A address.
- dl_din  out  36  delay-line write data: sample_in sign-extended to 36 bits.
- dl_dout  in  36  delay-line read data; registered, 1-cycle latency, read-before-write.
- cf_addr  out  8  coefficient RAM port A address (read only).
- cf_dout  in  36  coefficient read data; 1-cycle latency.

## Operation
- Reset values:
  - sample_out, sample_out_valid, busy, overrun, dl_we, dl_addr and cf_addr are 0.
  - The write pointer wp, the tap counter k and the accumulator are 0.
  - State is IDLE.
  - RAM contents are not cleared; delay-line history survives reset.
- States and transitions:
  - IDLE: on sample_valid, drive dl_we=1, dl_addr=wp, dl_din=sext(sample_in); go to MAC with k=0.
  - MAC: drive dl_addr=(wp-k) mod 256 and cf_addr=k. Increment k each cycle. After issuing k=TAPS-1, go to DRAIN.
  - DRAIN: wait for the pipeline to empty (3 cycles), then go to OUT.
  - OUT: register the rounded, saturated result. Pulse sample_out_valid. Increment wp (mod 256, natural wrap). Go to IDLE.
- Datapath pipeline:
  - Read-data stage.
  - Product register: the DATA_W x COEF_W signed product, 42 bits.
  - Accumulate into an ACC_W = DATA_W+COEF_W+8 = 50-bit signed accumulator. The accumulator is cleared on entry to MAC.
- Output arithmetic:
  - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half toward +inf.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Overrun:
  - sample_valid while busy=1 is dropped and sets overrun.
  - overrun is cleared only by reset.
  - sample_valid in the same cycle as the OUT-to-IDLE transition is also dropped.
- Reset mid-operation: processing aborts immediately, no sample_out_valid is produced, and wp returns to 0.

## Timing
- Acceptance edge is edge 0. busy rises at edge 0.
- Address issue runs on edges 1..TAPS, k=0..TAPS-1.
- The last product is accumulated at edge TAPS+3.
- sample_out and sample_out_valid update at edge TAPS+4. busy falls at the same edge.
- Latency is TAPS+4 cycles; the minimum sample spacing is TAPS+5 cycles. For TAPS=256 that is 261 cycles, well under the 2083 cycles per sample at 100 MHz / 48 kHz.
- The delay-line write at edge 0 is visible to the read at edge 1, because the read-before-write only affects the same-cycle read.
- sample_out holds its value until the next OUT state.

## Structure
- Package fir_pkg holds DATA_W, COEF_W, COEF_FRAC, ACC_W, the state encoding (IDLE, MAC, DRAIN, OUT) and a saturate function.
- Sub-module fir_mac_dp contains the product register, accumulator with clear, and round/saturate stage. fir_mac_seq keeps the FSM, wp, k and the RAM address generation.
- The bench instantiates two ram_256x36 models: delay line and coefficients, with coefficients preloaded via port B.

## Test plan
- **Impulse response.** TAPS=4, coefficients {0x10000, 0x08000, 0, 0}. Inputs 0x100000, 0, 0, 0 -> outputs 0x080000, 0x040000, 0, 0, each TAPS+4 = 8 cycles after its strobe.
- **Rounding.** TAPS=1, coefficient 0x10000.
  - Input 0x000003 -> output 0x000002.
  - Input 0xFFFFFD -> output 0xFFFFFF.
- **Saturation.** TAPS=4, all coefficients 0x1FFFF.
  - Four inputs of 0x7FFFFF -> fourth output 0x7FFFFF.
  - Four inputs of 0x800000 -> fourth output 0x800000.
- **Wrap-around.** TAPS=256, coefficient[255]=0x10000, all others 0. Send 300 samples with value n -> output n is (n-255)/2 rounded for n>=255. wp wraps through 255->0 with no glitch.
- **Overrun.**
  - Second sample_valid 10 cycles after the first -> overrun=1, exactly one sample_out_valid, and the second sample is absent from the delay line.
  - A strobe at TAPS+5 spacing -> no overrun.
- **Reset mid-MAC.** Assert rst_n=0 at edge 50 of a TAPS=256 run -> all outputs go to 0 asynchronously and no sample_out_valid appears. The next sample is written at address 0.
